z_test_ctrl: RTL and testbench
==============================

Name: z_test_ctrl

Overview:
Sequencer that owns the depth RAM and shares it between fragment depth tests and frame clears (glClear(GL_DEPTH_BUFFER_BIT)).
- Accepts one fragment at a time over a valid/ready handshake and performs the depth read-compare-conditional-write.
- Returns a pass/fail result over a second valid/ready handshake.
- Sits between the rasteriser fragment stream and a 1-cycle-read-latency depth RAM of X_RES*Y_RES words.

Parameters:
Z_SIZE, 8, depth width in bits
X_RES, 4, horizontal resolution
Y_RES, 4, vertical resolution
X_PIXEL_SIZE, $clog2(X_RES), x coordinate width
Y_PIXEL_SIZE, $clog2(Y_RES), y coordinate width
ADDR_W, $clog2(X_RES*Y_RES), RAM address width
TAG_W, 4, opaque fragment tag width
CLEAR_VAL, all-ones (255), value written by a clear (farthest)

Ports:
clk_i  in  1  clock; single clock domain
rst_ni  in  1  synchronous active-low reset
clear_i  in  1  clear request pulse; latched as pending
depth_func_i  in  3  GL compare code: 000 NEVER, 001 LESS, 010 LEQUAL, 011 GREATER, 100 GEQUAL, 101 EQUAL, 110 NOTEQUAL, 111 ALWAYS
depth_write_en_i  in  1  glDepthMask; write z on pass
frag_valid_i  in  1  fragment valid
frag_ready_o  out  1  fragment accepted when valid&&ready
frag_x_i  in  X_PIXEL_SIZE  fragment x
frag_y_i  in  Y_PIXEL_SIZE  fragment y
frag_z_i  in  Z_SIZE  fragment depth
frag_tag_i  in  TAG_W  tag
res_valid_o  out  1  result valid
res_ready_i  in  1  result consumed
res_pass_o  out  1  depth test result
res_tag_o  out  TAG_W  tag of the fragment
ram_addr_o  out  ADDR_W  RAM address
ram_rd_en_o  out  1  RAM read; data returns on ram_rdata_i the next cycle
ram_rdata_i  in  Z_SIZE  RAM read data
ram_wr_en_o  out  1  RAM write
ram_wdata_o  out  Z_SIZE  RAM write data
clear_busy_o  out  1  high while clear pending or running
clear_done_o  out  1  one-cycle pulse at clear end

Behaviour:
- Reset (rst_ni=0 at a clk_i edge):
  - State goes to IDLE; clear-pending flag and clear counter go to 0.
  - All outputs are 0: res_valid_o, res_pass_o, res_tag_o, clear_done_o, clear_busy_o, all ram_* enables.
  - RAM contents are untouched; software issues a clear after reset.
  - Reset mid-clear or mid-fragment aborts the operation; the in-flight result is lost.
- Address is y*X_RES + x.
- States: IDLE, CLEAR, RD, CMP, OUT.
- clear_i sets pending in any state. It is serviced only from IDLE, so the in-flight fragment finishes first. clear_i during CLEAR is absorbed and does not restart the clear.
- clear_busy_o = pending || state==CLEAR.
- IDLE:
  - If pending: go to CLEAR, counter=0.
  - Else frag_ready_o=1; on handshake capture x, y, z, tag, func, write_en, then go to RD.
  - frag_ready_o=0 in all other states and whenever pending=1, so clear has priority over a simultaneous fragment.
- CLEAR:
  - ram_wr_en_o=1, ram_addr_o=counter, ram_wdata_o=CLEAR_VAL; counter increments each cycle.
  - On counter==X_RES*Y_RES-1: pending is cleared, clear_done_o pulses the next cycle, go to IDLE.
  - A clear takes exactly X_RES*Y_RES cycles.
- RD: ram_rd_en_o=1 with the captured address; go to CMP.
- CMP:
  - Compare captured z (left operand) against ram_rdata_i, unsigned, per func. NEVER → 0, ALWAYS → 1.
  - If pass && write_en: ram_wr_en_o=1, same address, ram_wdata_o=z.
  - Register pass and tag, then go to OUT.
- OUT:
  - res_valid_o=1; res_pass_o and res_tag_o stay stable until res_ready_i.
  - On handshake go to IDLE.
- Out-of-range coordinate (x>=X_RES or y>=Y_RES): RD/CMP issue no RAM enables and pass is forced to 0.
- Latency: handshake at cycle T gives res_valid_o at T+3. Peak throughput is 1 fragment per 4 cycles.
- RAM enables are combinational from state; at most one of ram_rd_en_o and ram_wr_en_o is high per cycle.

Test Plan:
- Reset, then clear_i → 16 consecutive writes of 255 to addr 0..15; clear_done_o pulses once; clear_busy_o falls with it.
- LESS, write_en=1, frag (1,2) z=100 → addr 9 read; pass=1; write 100 at T+2; res_valid_o at T+3. Repeat z=100 → pass=0, no write.
- Loop all 8 funcs with stored 100 and z ∈ {99,100,101} → pass matches the GL truth table; write_en=0 never asserts ram_wr_en_o.
- clear_i asserted during CMP of a fragment → that result completes; CLEAR starts after the OUT handshake; a frag_valid_i held high is not accepted until clear_done_o.
- res_ready_i held low 5 cycles in OUT → res_pass_o and res_tag_o stable; frag_ready_o stays 0; no RAM activity.
- Fragment x=5 with X_RES=4 → no RAM enables; res_pass_o=0. Then reset asserted mid-CLEAR at counter=7 → all outputs 0 next cycle; no clear_done_o.

Source files
------------

// File: rtl/z_test_ctrl_if.sv
// z_test_ctrl_if: fragment, result and depth-RAM signals of the depth-test
// sequencer, bundled into one interface.
//   frag_*  : fragment request (valid/ready), rasteriser -> controller
//   res_*   : test result (valid/ready), controller -> consumer
//   ram_*   : depth RAM port (1-cycle read latency), controller -> RAM
// modport slave  : the controller's view (sinks fragments, drives the RAM)
// modport master : the environment's view (rasteriser, result sink, RAM)
interface z_test_ctrl_if #(
  parameter int Z_SIZE       = 8,
  parameter int X_PIXEL_SIZE = 2,
  parameter int Y_PIXEL_SIZE = 2,
  parameter int ADDR_W       = 4,
  parameter int TAG_W        = 4
);
  logic                    frag_valid;
  logic                    frag_ready;
  logic [X_PIXEL_SIZE-1:0] frag_x;
  logic [Y_PIXEL_SIZE-1:0] frag_y;
  logic [Z_SIZE-1:0]       frag_z;
  logic [TAG_W-1:0]        frag_tag;

  logic                    res_valid;
  logic                    res_ready;
  logic                    res_pass;
  logic [TAG_W-1:0]        res_tag;

  logic [ADDR_W-1:0]       ram_addr;
  logic                    ram_rd_en;
  logic [Z_SIZE-1:0]       ram_rdata;
  logic                    ram_wr_en;
  logic [Z_SIZE-1:0]       ram_wdata;

  modport slave (
    input  frag_valid, frag_x, frag_y, frag_z, frag_tag, res_ready, ram_rdata,
    output frag_ready, res_valid, res_pass, res_tag,
           ram_addr, ram_rd_en, ram_wr_en, ram_wdata
  );

  modport master (
    output frag_valid, frag_x, frag_y, frag_z, frag_tag, res_ready, ram_rdata,
    input  frag_ready, res_valid, res_pass, res_tag,
           ram_addr, ram_rd_en, ram_wr_en, ram_wdata
  );
endinterface

// File: rtl/z_test_ctrl.sv
// z_test_ctrl: owns the depth RAM and time-shares it between per-fragment
// depth tests (read, compare, conditional write) and whole-buffer clears.
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   clear_i            clear request pulse, remembered until serviced
//   depth_func_i       GL compare code, captured with each fragment
//   depth_write_en_i   depth mask, captured with each fragment
//   bus (slave)        fragment in, result out, depth RAM port
//   clear_busy_o       clear pending or running
//   clear_done_o       one-cycle pulse after the last clear write
module z_test_ctrl #(
  parameter int Z_SIZE       = 8,
  parameter int X_RES        = 4,
  parameter int Y_RES        = 4,
  parameter int X_PIXEL_SIZE = $clog2(X_RES),
  parameter int Y_PIXEL_SIZE = $clog2(Y_RES),
  parameter int ADDR_W       = $clog2(X_RES*Y_RES),
  parameter int TAG_W        = 4,
  parameter logic [Z_SIZE-1:0] CLEAR_VAL = '1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic [2:0] depth_func_i,
  input  logic       depth_write_en_i,
  z_test_ctrl_if.slave bus,
  output logic       clear_busy_o,
  output logic       clear_done_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(X_RES*Y_RES - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, RD, CMP, OUT} state_t;

  state_t              state, nxt;
  logic                pending;
  logic [ADDR_W-1:0]   cnt;
  logic                done;
  logic [ADDR_W-1:0]   cap_addr;
  logic                cap_oor;
  logic [Z_SIZE-1:0]   cap_z;
  logic [TAG_W-1:0]    cap_tag;
  logic [2:0]          cap_func;
  logic                cap_we;
  logic                res_pass, cmp, pass;
  logic [TAG_W-1:0]    res_tag;

  logic                frag_ready, res_valid, rd_en, wr_en;
  logic [ADDR_W-1:0]   addr;
  logic [Z_SIZE-1:0]   wdata;
  logic [ADDR_W-1:0]   frag_addr;
  logic                frag_oor, take;

  // Linear address; only meaningful when the coordinate is in range.
  assign frag_addr = ADDR_W'(bus.frag_y) * ADDR_W'(Y_RES > 0 ? X_RES : 0)
                   + ADDR_W'(bus.frag_x);
  assign frag_oor  = (32'(bus.frag_x) >= 32'(X_RES)) ||
                     (32'(bus.frag_y) >= 32'(Y_RES));
  assign take      = (state == IDLE) && !pending && bus.frag_valid;

  // Captured z is the left operand: pass means "z <op> stored".
  always_comb begin
    cmp = 1'b0;
    case (cap_func)
      3'd0:    cmp = 1'b0;
      3'd1:    cmp = cap_z <  bus.ram_rdata;
      3'd2:    cmp = cap_z <= bus.ram_rdata;
      3'd3:    cmp = cap_z >  bus.ram_rdata;
      3'd4:    cmp = cap_z >= bus.ram_rdata;
      3'd5:    cmp = cap_z == bus.ram_rdata;
      3'd6:    cmp = cap_z != bus.ram_rdata;
      default: cmp = 1'b1;
    endcase
  end
  assign pass = cmp && !cap_oor;

  always_comb begin
    nxt        = state;
    frag_ready = 1'b0;
    res_valid  = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    addr       = cap_addr;
    wdata      = cap_z;
    case (state)
      IDLE: begin
        // A pending clear blocks fragment intake so it wins ties.
        if (pending) nxt = CLEAR;
        else begin
          frag_ready = 1'b1;
          if (bus.frag_valid) nxt = RD;
        end
      end
      CLEAR: begin
        wr_en = 1'b1;
        addr  = cnt;
        wdata = CLEAR_VAL;
        if (cnt == LAST) nxt = IDLE;
      end
      RD: begin
        rd_en = !cap_oor;
        nxt   = CMP;
      end
      CMP: begin
        wr_en = pass && cap_we;
        nxt   = OUT;
      end
      OUT: begin
        res_valid = 1'b1;
        if (bus.res_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= IDLE;
      pending  <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      cap_addr <= '0;
      cap_oor  <= 1'b0;
      cap_z    <= '0;
      cap_tag  <= '0;
      cap_func <= '0;
      cap_we   <= 1'b0;
      res_pass <= 1'b0;
      res_tag  <= '0;
    end else begin
      state <= nxt;
      // Ending the clear drops any request that arrived during it.
      if (state == CLEAR && cnt == LAST) pending <= 1'b0;
      else if (clear_i)                  pending <= 1'b1;
      done <= (state == CLEAR) && (cnt == LAST);
      cnt  <= (state == CLEAR) ? cnt + 1'b1 : '0;
      if (take) begin
        cap_addr <= frag_addr;
        cap_oor  <= frag_oor;
        cap_z    <= bus.frag_z;
        cap_tag  <= bus.frag_tag;
        cap_func <= depth_func_i;
        cap_we   <= depth_write_en_i;
      end
      if (state == CMP) begin
        res_pass <= pass;
        res_tag  <= cap_tag;
      end
    end
  end

  assign bus.frag_ready = frag_ready;
  assign bus.res_valid  = res_valid;
  assign bus.res_pass   = res_pass;
  assign bus.res_tag    = res_tag;
  assign bus.ram_addr   = addr;
  assign bus.ram_rd_en  = rd_en;
  assign bus.ram_wr_en  = wr_en;
  assign bus.ram_wdata  = wdata;
  assign clear_busy_o   = pending || (state == CLEAR);
  assign clear_done_o   = done;

endmodule

// File: tb/tb_z_test_ctrl.sv
// Directed bench for z_test_ctrl with a behavioural 16-word depth RAM.
// Coordinate ports are widened to 3 bits so out-of-range x can be driven.
module tb_z_test_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] func = 3'd0;
  logic       we = 1'b0;
  logic       busy, done;
  int         vecs = 0;
  int         errs = 0;

  always #5 clk = ~clk;

  z_test_ctrl_if #(.Z_SIZE(8), .X_PIXEL_SIZE(3), .Y_PIXEL_SIZE(3),
                   .ADDR_W(4), .TAG_W(4)) bus();

  z_test_ctrl #(.X_PIXEL_SIZE(3), .Y_PIXEL_SIZE(3)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .depth_func_i(func),
    .depth_write_en_i(we), .bus(bus), .clear_busy_o(busy),
    .clear_done_o(done));

  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (bus.ram_wr_en) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_rd_en) bus.ram_rdata <= mem[bus.ram_addr];
  end

  typedef struct {
    logic [2:0] f;
    logic [7:0] z;
    logic       pass;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input int x, input int y, input logic [7:0] z,
                       input logic [3:0] tag, input logic [2:0] f,
                       input logic w);
    bus.frag_x = 3'(x); bus.frag_y = 3'(y); bus.frag_z = z;
    bus.frag_tag = tag; func = f; we = w; bus.frag_valid = 1'b1;
    for (int n = 0; n < 64; n++) begin
      if (bus.frag_ready) break;
      tick();
    end
    chk("frag_ready", bus.frag_ready, 1);
  endtask

  // Called at the negedge where the handshake is pending; walks RD/CMP/OUT.
  task automatic finish(input int a, input logic oor, input logic p,
                        input logic w, input logic [7:0] z,
                        input logic [3:0] tag, input int hold);
    tick(); bus.frag_valid = 1'b0;
    chk("rd_en", bus.ram_rd_en, !oor);
    chk("rd_wr_en", bus.ram_wr_en, 0);
    if (!oor) chk("rd_addr", bus.ram_addr, a);
    tick();
    chk("cmp_wr_en", bus.ram_wr_en, w);
    chk("cmp_rd_en", bus.ram_rd_en, 0);
    if (w) begin
      chk("cmp_wdata", bus.ram_wdata, z);
      chk("cmp_addr", bus.ram_addr, a);
    end
    tick();
    for (int h = 0; h <= hold; h++) begin
      chk("res_valid", bus.res_valid, 1);
      chk("res_pass", bus.res_pass, p);
      chk("res_tag", bus.res_tag, tag);
      chk("out_frag_ready", bus.frag_ready, 0);
      chk("out_ram_en", bus.ram_rd_en | bus.ram_wr_en, 0);
      if (h < hold) tick();
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("res_valid_drop", bus.res_valid, 0);
  endtask

  initial begin
    vec_t tbl [24];
    int   bad, wrs, dn;
    tbl = '{
      '{3'd0, 8'd99, 1'b0}, '{3'd0, 8'd100, 1'b0}, '{3'd0, 8'd101, 1'b0},
      '{3'd1, 8'd99, 1'b1}, '{3'd1, 8'd100, 1'b0}, '{3'd1, 8'd101, 1'b0},
      '{3'd2, 8'd99, 1'b1}, '{3'd2, 8'd100, 1'b1}, '{3'd2, 8'd101, 1'b0},
      '{3'd3, 8'd99, 1'b0}, '{3'd3, 8'd100, 1'b0}, '{3'd3, 8'd101, 1'b1},
      '{3'd4, 8'd99, 1'b0}, '{3'd4, 8'd100, 1'b1}, '{3'd4, 8'd101, 1'b1},
      '{3'd5, 8'd99, 1'b0}, '{3'd5, 8'd100, 1'b1}, '{3'd5, 8'd101, 1'b0},
      '{3'd6, 8'd99, 1'b1}, '{3'd6, 8'd100, 1'b0}, '{3'd6, 8'd101, 1'b1},
      '{3'd7, 8'd99, 1'b1}, '{3'd7, 8'd100, 1'b1}, '{3'd7, 8'd101, 1'b1}};
    bus.frag_valid = 1'b0; bus.frag_x = '0; bus.frag_y = '0;
    bus.frag_z = '0; bus.frag_tag = '0; bus.res_ready = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_pass", bus.res_pass, 0);
    chk("rst_res_tag", bus.res_tag, 0);
    chk("rst_ram_en", bus.ram_rd_en | bus.ram_wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    // Full clear: 16 writes of 255 to 0..15
    clear = 1'b1;
    tick(); clear = 1'b0;
    chk("clr_pending_busy", busy, 1);
    chk("clr_pending_wr", bus.ram_wr_en, 0);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (!bus.ram_wr_en || bus.ram_addr != 4'(i) ||
          bus.ram_wdata != 8'hFF || done || !busy) bad++;
    end
    chk("clr_write_cycles_bad", bad, 0);
    tick();
    chk("clr_done_pulse", done, 1);
    chk("clr_busy_fall", busy, 0);
    chk("clr_after_wr", bus.ram_wr_en, 0);
    tick();
    chk("clr_done_single", done, 0);
    bad = 0;
    for (int i = 0; i < 16; i++) if (mem[i] != 8'hFF) bad++;
    chk("clr_mem_bad", bad, 0);

    // LESS with write: (1,2) -> addr 9, then repeat fails
    issue(1, 2, 8'd100, 4'd1, 3'd1, 1'b1);
    finish(9, 1'b0, 1'b1, 1'b1, 8'd100, 4'd1, 0);
    chk("mem9_after_write", mem[9], 100);
    issue(1, 2, 8'd100, 4'd2, 3'd1, 1'b1);
    finish(9, 1'b0, 1'b0, 1'b0, 8'd100, 4'd2, 0);

    // Compare truth table against stored 100, depth mask off
    for (int i = 0; i < 24; i++) begin
      issue(1, 2, tbl[i].z, 4'(i), tbl[i].f, 1'b0);
      finish(9, 1'b0, tbl[i].pass, 1'b0, tbl[i].z, 4'(i), 0);
    end
    chk("mem9_unchanged", mem[9], 100);

    // Clear raised during CMP; held fragment waits for clear_done
    issue(0, 0, 8'd10, 4'hA, 3'd1, 1'b1);
    tick(); bus.frag_valid = 1'b0;
    tick();
    clear = 1'b1;
    chk("cc_cmp_wr_en", bus.ram_wr_en, 1);
    tick(); clear = 1'b0;
    chk("cc_res_valid", bus.res_valid, 1);
    chk("cc_res_pass", bus.res_pass, 1);
    chk("cc_busy", busy, 1);
    bus.frag_x = 3'd2; bus.frag_y = 3'd2; bus.frag_z = 8'd50;
    bus.frag_tag = 4'd5; func = 3'd1; we = 1'b0; bus.frag_valid = 1'b1;
    bus.res_ready = 1'b1;
    tick(); bus.res_ready = 1'b0;
    chk("cc_idle_ready", bus.frag_ready, 0);
    chk("cc_idle_wr", bus.ram_wr_en, 0);
    bad = 0; wrs = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (done) break;
      if (bus.frag_ready) bad++;
      if (bus.ram_wr_en) wrs++;
    end
    chk("cc_done_seen", done, 1);
    chk("cc_ready_during_clear", bad, 0);
    chk("cc_clear_writes", wrs, 16);
    chk("cc_ready_at_done", bus.frag_ready, 1);
    finish(10, 1'b0, 1'b1, 1'b0, 8'd50, 4'd5, 0);
    chk("cc_mem0_cleared", mem[0], 255);

    // Result held 5 extra cycles
    issue(3, 3, 8'd200, 4'd7, 3'd2, 1'b1);
    finish(15, 1'b0, 1'b1, 1'b1, 8'd200, 4'd7, 5);
    chk("mem15_after_hold", mem[15], 200);

    // Out-of-range x: no RAM access, forced fail even with ALWAYS
    issue(5, 1, 8'd0, 4'd3, 3'd7, 1'b1);
    finish(0, 1'b1, 1'b0, 1'b0, 8'd0, 4'd3, 0);

    // Reset in the middle of a clear
    clear = 1'b1;
    tick(); clear = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("mid_clr_addr", bus.ram_addr, 7);
    chk("mid_clr_wr", bus.ram_wr_en, 1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_wr", bus.ram_wr_en, 0);
    chk("mid_rst_rd", bus.ram_rd_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_res_tag", bus.res_tag, 0);
    chk("mid_rst_res_valid", bus.res_valid, 0);
    rst_n = 1'b1;
    dn = 0; wrs = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (done) dn++;
      if (bus.ram_wr_en) wrs++;
    end
    chk("post_rst_done_pulses", dn, 0);
    chk("post_rst_writes", wrs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
